argmax_frame_scheduler: RTL and testbench

- Sequences the final classification stage: accepts one frame of NUM_CLASSES unsigned output-layer scores, arriving serially over a valid/ready stream, and tracks a running maximum.
- Presents the winning class Index and its score on a held result handshake.
- Sits between the output-layer accumulator stream and the top-level result register and host interface.
- Owns frame start, abort and watchdog timeout.

---
 rtl/argmax_pkg.sv | 14 +
 rtl/argmax_running_cmp.sv | 36 +++
 rtl/argmax_frame_scheduler.sv | 123 ++++++++++++
 tb/tb_argmax_frame_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared types and constants for the argmax frame scheduler.
// State encoding and index widths used by the top and the compare unit.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  localparam int INDEX_W = 4;
  localparam logic [INDEX_W-1:0] INDEX_NONE = 4'hF;

endpackage

// File: rtl/argmax_running_cmp.sv
// Running maximum tracker: strictly-greater update, lowest index wins ties.
// nxt_* expose this beat's compare so the final beat can be captured directly.
module argmax_running_cmp
  import argmax_pkg::*;
#(
  parameter int W = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               first,
  input  logic               accept,
  input  logic [INDEX_W-1:0] beat_idx,
  input  logic [W-1:0]       score,
  output logic [W-1:0]       nxt_max,
  output logic [INDEX_W-1:0] nxt_idx
);

  logic [W-1:0]       max_q;
  logic [INDEX_W-1:0] idx_q;
  logic               upd;

  assign upd     = first || (score > max_q);
  assign nxt_max = upd ? score : max_q;
  assign nxt_idx = upd ? beat_idx : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      max_q <= nxt_max;
      idx_q <= nxt_idx;
    end
  end

endmodule

// File: rtl/argmax_frame_scheduler.sv
// Frame sequencer for the final argmax stage: collect, watchdog, result.
// Start in COLLECT restarts the frame; Start beats timeout.
module argmax_frame_scheduler
  import argmax_pkg::*;
#(
  parameter int NUM_SIZE    = 26,
  parameter int NUM_CLASSES = 10,
  parameter int TIMEOUT     = 1023
) (
  input  logic                Clk,
  input  logic                GlobalResetN,
  input  logic                Start,
  input  logic                ScoreValid,
  output logic                ScoreReady,
  input  logic [NUM_SIZE-1:0] Score,
  output logic                ResultValid,
  input  logic                ResultReady,
  output logic [3:0]          Index,
  output logic [NUM_SIZE-1:0] MaxScore,
  output logic                Busy,
  output logic                Timeout
);

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int CW = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LIM =
    WD_EN ? CW'(TIMEOUT - 1) : '0;
  localparam logic [INDEX_W-1:0] LAST_BEAT =
    INDEX_W'(NUM_CLASSES - 1);

  state_t              state;
  logic [INDEX_W-1:0]  beat;
  logic [CW-1:0]       idle;
  logic                accept;
  logic                last;
  logic                wd;
  logic [NUM_SIZE-1:0] nxt_max;
  logic [INDEX_W-1:0]  nxt_idx;

  assign ScoreReady = (state == COLLECT);
  assign accept = ScoreValid && ScoreReady && !Start;
  assign last   = accept && (beat == LAST_BEAT);
  assign wd     = WD_EN && ScoreReady && !Start &&
                  !accept && (idle == WD_LIM);

  argmax_running_cmp #(.W(NUM_SIZE)) u_cmp (
    .clk      (Clk),
    .rst_n    (GlobalResetN),
    .first    (beat == '0),
    .accept   (accept),
    .beat_idx (beat),
    .score    (Score),
    .nxt_max  (nxt_max),
    .nxt_idx  (nxt_idx)
  );

  always_ff @(posedge Clk or negedge GlobalResetN) begin
    if (!GlobalResetN) begin
      state       <= IDLE;
      beat        <= '0;
      idle        <= '0;
      Index       <= INDEX_NONE;
      MaxScore    <= '0;
      ResultValid <= 1'b0;
      Busy        <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      Timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            state <= COLLECT;
            beat  <= '0;
            idle  <= '0;
            Busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (Start) begin
            beat <= '0;
            idle <= '0;
          end else if (accept) begin
            idle <= '0;
            if (last) begin
              state       <= RESULT;
              beat        <= '0;
              ResultValid <= 1'b1;
              Index       <= nxt_idx;
              MaxScore    <= nxt_max;
            end else begin
              beat <= beat + 1'b1;
            end
          end else if (wd) begin
            state   <= IDLE;
            idle    <= '0;
            Busy    <= 1'b0;
            Timeout <= 1'b1;
          end else begin
            idle <= idle + 1'b1;
          end
        end
        RESULT: begin
          if (ResultReady) begin
            ResultValid <= 1'b0;
            if (Start) begin
              state <= COLLECT;
              beat  <= '0;
              idle  <= '0;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_frame_scheduler.sv
// Scoreboard bench for argmax_frame_scheduler.
// Expected results are queued at stimulus time and popped on handshake.
module tb_argmax_frame_scheduler;

  localparam int W = 26;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sv;
  logic         sr;
  logic [W-1:0] score;
  logic         rv;
  logic         rr;
  logic [3:0]   idx;
  logic [W-1:0] mx;
  logic         busy;
  logic         tmo;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]   frame [N];
  logic [4+W-1:0] exp_q [$];
  logic [3:0]     last_idx;
  logic [W-1:0]   last_max;

  always #5 clk = ~clk;

  argmax_frame_scheduler #(
    .NUM_SIZE    (W),
    .NUM_CLASSES (N),
    .TIMEOUT     (8)
  ) dut (
    .Clk          (clk),
    .GlobalResetN (rst_n),
    .Start        (start),
    .ScoreValid   (sv),
    .ScoreReady   (sr),
    .Score        (score),
    .ResultValid  (rv),
    .ResultReady  (rr),
    .Index        (idx),
    .MaxScore     (mx),
    .Busy         (busy),
    .Timeout      (tmo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rv && rr) begin
      if (exp_q.size() == 0) begin
        chk("extra_result", 32'd1, 32'd0);
      end else begin
        logic [4+W-1:0] e;
        e = exp_q.pop_front();
        chk("res_idx", 32'(idx), 32'(e[4+W-1:W]));
        chk("res_max", 32'(mx), 32'(e[W-1:0]));
      end
    end
  end

  task automatic push_model();
    logic [3:0]   bi;
    logic [W-1:0] bm;
    bi = 4'd0;
    bm = frame[0];
    for (int k = 1; k < N; k++) begin
      if (frame[k] > bm) begin
        bm = frame[k];
        bi = 4'(k);
      end
    end
    exp_q.push_back({bi, bm});
    last_idx = bi;
    last_max = bm;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beats(input int first, input int n,
                             input int gap_max);
    for (int k = first; k < first + n; k++) begin
      sv = 1'b0;
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk); #1;
      end
      sv    = 1'b1;
      score = frame[k];
      @(posedge clk); #1;
    end
    sv = 1'b0;
  endtask

  task automatic run_frame(input bit do_start, input int gap_max);
    push_model();
    if (do_start) pulse_start();
    drive_beats(0, N, gap_max);
    chk("latency_rv", 32'(rv), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sv    = 1'b0;
    score = '0;
    rr    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idx", 32'(idx), 32'hF);
    chk("rst_max", 32'(mx), 32'd0);
    chk("rst_rv", 32'(rv), 32'd0);
    chk("rst_sr", 32'(sr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame = '{5, 9, 3, 12, 7, 12, 1, 0, 11, 2};
    run_frame(1'b1, 0);
    @(posedge clk); #1;
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_rv", 32'(rv), 32'd0);

    for (int k = 0; k < N; k++) frame[k] = 26'h3FFFFFF;
    run_frame(1'b1, 0);
    @(posedge clk); #1;

    frame = '{4, 8, 8, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1'b1, 0);
    @(posedge clk); #1;

    for (int k = 0; k < N; k++) frame[k] = W'($urandom_range(500, 0));
    rr = 1'b0;
    run_frame(1'b1, 2);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("hold_rv", 32'(rv), 32'd1);
      chk("hold_idx", 32'(idx), 32'(last_idx));
      chk("hold_max", 32'(mx), 32'(last_max));
    end
    for (int k = 0; k < N; k++) frame[k] = W'($urandom_range(500, 0));
    rr    = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_start_sr", 32'(sr), 32'd1);
    chk("hs_start_rv", 32'(rv), 32'd0);
    run_frame(1'b0, 2);
    @(posedge clk); #1;

    for (int k = 0; k < N; k++) frame[k] = 50;
    pulse_start();
    drive_beats(0, 4, 0);
    start = 1'b1;
    sv    = 1'b1;
    score = 100;
    @(posedge clk); #1;
    start = 1'b0;
    sv    = 1'b0;
    frame = '{3, 7, 19, 2, 11, 19, 20, 5, 0, 20};
    push_model();
    drive_beats(0, N, 1);
    chk("abort_rv", 32'(rv), 32'd1);
    chk("abort_idx", 32'(idx), 32'd6);
    chk("abort_max", 32'(mx), 32'd20);
    @(posedge clk); #1;

    for (int k = 0; k < N; k++) frame[k] = 77;
    pulse_start();
    drive_beats(0, 5, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_idx", 32'(idx), 32'hF);
    chk("mrst_max", 32'(mx), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_sr", 32'(sr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("mrst_no_rv", 32'(rv), 32'd0);

    frame = '{1, 2, 3, 4, 5, 6, 7, 300, 9, 10};
    run_frame(1'b1, 0);
    @(posedge clk); #1;
    pulse_start();
    drive_beats(0, 3, 0);
    repeat (7) @(posedge clk);
    #1;
    chk("wd_early", 32'(tmo), 32'd0);
    chk("wd_busy_early", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("wd_pulse", 32'(tmo), 32'd1);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_sr", 32'(sr), 32'd0);
    chk("wd_rv", 32'(rv), 32'd0);
    chk("wd_idx", 32'(idx), 32'(last_idx));
    chk("wd_max", 32'(mx), 32'(last_max));
    @(posedge clk); #1;
    chk("wd_one_cycle", 32'(tmo), 32'd0);

    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
